// File: rtl/lorenz_pkg.sv
// Shared types and constants for the Lorenz stepper: FSM state encoding, default 7.20 format,
// and a real-to-Q7.20 conversion helper for stimulus generation.
package lorenz_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MUL0   = 3'd1,
        ST_MUL1   = 3'd2,
        ST_MUL2   = 3'd3,
        ST_MUL3   = 3'd4,
        ST_UPDATE = 3'd5
    } lorenz_state_t;

    localparam int LZ_W        = 27;
    localparam int LZ_FRAC     = 20;
    localparam int LZ_DT_SHIFT = 8;

    // Rounds to nearest; only meaningful for the default 7.20 format.
    function automatic logic signed [LZ_W-1:0] to_q720(input real r);
        real s;
        s = r * 1048576.0;
        return LZ_W'($rtoi((s >= 0.0) ? (s + 0.5) : (s - 0.5)));
    endfunction

endpackage

// File: rtl/lorenz_stepper_if.sv
// Host/display-side bundle of the Lorenz stepper: configuration in, state and step strobe out.
// No backpressure: the consumer must take each sample in its step_done cycle.
interface lorenz_stepper_if #(
    parameter int W     = 27,
    parameter int CNT_W = 32
);
    logic                load;
    logic                run;
    logic signed [W-1:0] init_x;
    logic signed [W-1:0] init_y;
    logic signed [W-1:0] init_z;
    logic signed [W-1:0] sigma;
    logic signed [W-1:0] rho;
    logic signed [W-1:0] beta;
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    logic signed [W-1:0] z;
    logic                busy;
    logic                step_done;
    logic [CNT_W-1:0]    step_count;

    modport master (
        output load, run, init_x, init_y, init_z, sigma, rho, beta,
        input  x, y, z, busy, step_done, step_count
    );

    modport slave (
        input  load, run, init_x, init_y, init_z, sigma, rho, beta,
        output x, y, z, busy, step_done, step_count
    );
endinterface

// File: rtl/lorenz_stepper_fxp_mult.sv
// Combinational signed fixed-point multiply keeping W bits at binary point FRAC; zero latency.
// LORENZ_SAT_EN clamps out-of-range products, otherwise the legacy sign+low-bits wrap is kept.
module fxp_mult #(
    parameter int W    = 27,
    parameter int FRAC = 20
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] p
);
    logic signed [2*W-1:0] full;

    assign full = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};

`ifdef LORENZ_SAT_EN
    logic [W-FRAC:0] hi;
    logic            unused_bits;

    // Product fits when everything above the kept field is a copy of the sign.
    assign hi = full[2*W-1:W-1+FRAC];

    always_comb begin
        p = full[W-1+FRAC:FRAC];
        if (!(hi == '0 || hi == '1)) begin
            p = full[2*W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

    assign unused_bits = ^full[FRAC-1:0];
`else
    logic unused_bits;

    assign p           = {full[2*W-1], full[W-2+FRAC:FRAC]};
    assign unused_bits = ^{full[2*W-2:W-1+FRAC], full[FRAC-1:0]};
`endif

endmodule

// File: rtl/lorenz_stepper.sv
// Forward-Euler Lorenz stepper on one shared multiplier; step accepted at edge k lands at k+5.
// No backpressure; load aborts any step. LORENZ_SAT_EN selects saturating instead of wrapping math.
module lorenz_stepper
    import lorenz_pkg::*;
#(
    parameter int W        = LZ_W,
    parameter int FRAC     = LZ_FRAC,
    parameter int DT_SHIFT = LZ_DT_SHIFT,
    parameter int CNT_W    = 32
) (
    input  logic            clk,
    input  logic            reset,
    lorenz_stepper_if.slave bus
);
    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_MUL0   = ST_MUL0;
    localparam logic [2:0] S_MUL1   = ST_MUL1;
    localparam logic [2:0] S_MUL2   = ST_MUL2;
    localparam logic [2:0] S_MUL3   = ST_MUL3;
    localparam logic [2:0] S_UPDATE = ST_UPDATE;

    logic [2:0]          state;
    logic signed [W-1:0] x_q, y_q, z_q;
    logic signed [W-1:0] sigma_q, rho_q, beta_q;
    logic signed [W-1:0] p0, p1, p2, p3;
    logic signed [W-1:0] mul_a, mul_b, mul_p;
    logic signed [W-1:0] x_nxt, y_nxt, z_nxt;
    logic [CNT_W-1:0]    step_count_q;
    logic                step_done_q;
    logic                accept;

    fxp_mult #(.W(W), .FRAC(FRAC)) u_mult (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            S_MUL0: begin mul_a = sigma_q; mul_b = y_q - x_q;   end
            S_MUL1: begin mul_a = x_q;     mul_b = rho_q - z_q; end
            S_MUL2: begin mul_a = x_q;     mul_b = y_q;         end
            S_MUL3: begin mul_a = beta_q;  mul_b = z_q;         end
            default: ;
        endcase
    end

`ifdef LORENZ_SAT_EN
    localparam logic signed [W:0] MAX_V = {2'b00, {(W-1){1'b1}}};
    localparam logic signed [W:0] MIN_V = {2'b11, {(W-1){1'b0}}};

    function automatic logic signed [W:0] sext(input logic signed [W-1:0] v);
        return {v[W-1], v};
    endfunction

    function automatic logic signed [W-1:0] clamp(input logic signed [W:0] v);
        if (v > MAX_V) return MAX_V[W-1:0];
        if (v < MIN_V) return MIN_V[W-1:0];
        return v[W-1:0];
    endfunction

    logic signed [W:0] sum_x, sum_y, sum_z;

    always_comb begin
        sum_x = sext(x_q) + (sext(p0) >>> DT_SHIFT);
        sum_y = sext(y_q) + ((sext(p1) - sext(y_q)) >>> DT_SHIFT);
        sum_z = sext(z_q) + ((sext(p2) - sext(p3)) >>> DT_SHIFT);
        x_nxt = clamp(sum_x);
        y_nxt = clamp(sum_y);
        z_nxt = clamp(sum_z);
    end
`else
    always_comb begin
        x_nxt = x_q + (p0 >>> DT_SHIFT);
        y_nxt = y_q + ((p1 - y_q) >>> DT_SHIFT);
        z_nxt = z_q + ((p2 - p3) >>> DT_SHIFT);
    end
`endif

    assign accept = bus.run && ((state == S_IDLE) || (state == S_UPDATE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            z_q          <= '0;
            sigma_q      <= '0;
            rho_q        <= '0;
            beta_q       <= '0;
            p0           <= '0;
            p1           <= '0;
            p2           <= '0;
            p3           <= '0;
            step_count_q <= '0;
            step_done_q  <= 1'b0;
        end else begin
            step_done_q <= 1'b0;
            if (bus.load) begin
                x_q          <= bus.init_x;
                y_q          <= bus.init_y;
                z_q          <= bus.init_z;
                step_count_q <= '0;
                state        <= S_IDLE;
            end else begin
                // Parameters are frozen at acceptance so mid-step host writes hit the next step.
                if (accept) begin
                    sigma_q <= bus.sigma;
                    rho_q   <= bus.rho;
                    beta_q  <= bus.beta;
                end
                case (state)
                    S_IDLE:   if (bus.run) state <= S_MUL0;
                    S_MUL0:   begin p0 <= mul_p; state <= S_MUL1;   end
                    S_MUL1:   begin p1 <= mul_p; state <= S_MUL2;   end
                    S_MUL2:   begin p2 <= mul_p; state <= S_MUL3;   end
                    S_MUL3:   begin p3 <= mul_p; state <= S_UPDATE; end
                    S_UPDATE: begin
                        x_q          <= x_nxt;
                        y_q          <= y_nxt;
                        z_q          <= z_nxt;
                        step_count_q <= step_count_q + CNT_W'(1);
                        step_done_q  <= 1'b1;
                        state        <= bus.run ? S_MUL0 : S_IDLE;
                    end
                    default:  state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.x          = x_q;
    assign bus.y          = y_q;
    assign bus.z          = z_q;
    assign bus.busy       = (state != S_IDLE);
    assign bus.step_done  = step_done_q;
    assign bus.step_count = step_count_q;

endmodule

// File: tb/tb_lorenz_stepper.sv
// Directed bench for lorenz_stepper: single-step vector table plus multi-cycle sequences
// (continuous run, load abort, parameter change, reset mid-step) against a bit-accurate model.
module tb_lorenz_stepper;
    import lorenz_pkg::*;

    localparam int     W     = 27;
    localparam int     DT    = 8;
    localparam longint MASKW = 64'h7FFFFFF;
    localparam longint SIGNW = 64'h8000000;
    localparam longint MASKM = 64'h3FFFFFF;
    localparam longint SPANM = 64'h4000000;
    localparam longint VMAX  = 67108863;
    localparam longint VMIN  = -67108864;

    typedef struct {
        longint ix, iy, iz;
        longint sg, rh, bt;
        longint ex, ey, ez;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    longint mx, my, mz, ms, mr, mb;
    vec_t tbl[4];

    always #5 clk = ~clk;

    lorenz_stepper_if #(.W(W), .CNT_W(32)) bus ();

    lorenz_stepper #(.W(W), .FRAC(20), .DT_SHIFT(DT), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint wrapw(input longint v);
        longint m;
        m = v & MASKW;
        if (m[W-1]) m = m - SIGNW;
        return m;
    endfunction

    function automatic longint clampw(input longint v);
        if (v > VMAX) return VMAX;
        if (v < VMIN) return VMIN;
        return v;
    endfunction

    function automatic longint m_mul(input longint a, input longint b);
        longint p, q;
        p = a * b;
        q = p >>> 20;
`ifdef LORENZ_SAT_EN
        return clampw(q);
`else
        q = q & MASKM;
        return (p < 0) ? q - SPANM : q;
`endif
    endfunction

    task automatic model_step();
        longint p0, p1, p2, p3, nx, ny, nz;
        p0 = m_mul(ms, wrapw(my - mx));
        p1 = m_mul(mx, wrapw(mr - mz));
        p2 = m_mul(mx, my);
        p3 = m_mul(mb, mz);
`ifdef LORENZ_SAT_EN
        nx = clampw(mx + (p0 >>> DT));
        ny = clampw(my + ((p1 - my) >>> DT));
        nz = clampw(mz + ((p2 - p3) >>> DT));
`else
        nx = wrapw(mx + (p0 >>> DT));
        ny = wrapw(my + (wrapw(p1 - my) >>> DT));
        nz = wrapw(mz + (wrapw(p2 - p3) >>> DT));
`endif
        mx = nx;
        my = ny;
        mz = nz;
    endtask

    task automatic do_load(input vec_t v);
        bus.init_x = W'(v.ix);
        bus.init_y = W'(v.iy);
        bus.init_z = W'(v.iz);
        bus.sigma  = W'(v.sg);
        bus.rho    = W'(v.rh);
        bus.beta   = W'(v.bt);
        mx = v.ix; my = v.iy; mz = v.iz;
        ms = v.sg; mr = v.rh; mb = v.bt;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            tick();
            if (bus.step_done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic chk_xyz(input string pfx, input longint ex, input longint ey, input longint ez);
        chk({pfx, "_x"}, bus.x, ex);
        chk({pfx, "_y"}, bus.y, ey);
        chk({pfx, "_z"}, bus.z, ez);
    endtask

    initial begin
        int n, pulses, last;

        // beta*z exceeds the 7.20 range for the first vector, so p3 wraps (or saturates).
        tbl[0] = '{-1048576, 64'h1999A, to_q720(25.0), to_q720(10.0), to_q720(28.0), 64'h2AABAA,
`ifdef LORENZ_SAT_EN
                   -1003520, 92160, 25951846};
`else
                   -1003520, 92160, 26203042};
`endif
        tbl[1] = '{to_q720(1.0), to_q720(2.0), to_q720(3.0), to_q720(10.0), to_q720(28.0), to_q720(2.0),
                   1089536, 2191360, 3129344};
        tbl[2] = '{to_q720(-2.0), to_q720(-3.0), to_q720(0.5), to_q720(1.0), 0, to_q720(4.0),
                   -2101248, -3129344, 540672};
        tbl[3] = '{to_q720(60.0), to_q720(60.0), 0, to_q720(10.0), to_q720(28.0), 64'h2AABAA,
`ifdef LORENZ_SAT_EN
                   62914560, 62930943, 262143};
`else
                   62914560, 62734336, 65536};
`endif

        bus.load = 1'b0; bus.run = 1'b0;
        bus.init_x = '0; bus.init_y = '0; bus.init_z = '0;
        bus.sigma = '0; bus.rho = '0; bus.beta = '0;

        repeat (3) tick();
        chk_xyz("rst", 0, 0, 0);
        chk("rst_count", bus.step_count, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.step_done, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            do_load(tbl[i]);
            chk_xyz($sformatf("v%0d_load", i), tbl[i].ix, tbl[i].iy, tbl[i].iz);
            chk($sformatf("v%0d_load_count", i), bus.step_count, 0);
            chk($sformatf("v%0d_load_busy", i), bus.busy, 0);
            bus.run = 1'b1;
            tick();
            chk($sformatf("v%0d_accept_busy", i), bus.busy, 1);
            bus.run = 1'b0;
            wait_done(20, n);
            chk($sformatf("v%0d_latency", i), n, 5);
            chk_xyz($sformatf("v%0d_step", i), tbl[i].ex, tbl[i].ey, tbl[i].ez);
            chk($sformatf("v%0d_count", i), bus.step_count, 1);
            chk($sformatf("v%0d_idle", i), bus.busy, 0);
            tick();
            chk($sformatf("v%0d_pulse_len", i), bus.step_done, 0);
        end

        do_load(tbl[0]);
        bus.run = 1'b1;
        pulses = 0;
        last = 1;
        for (int c = 1; c <= 1100 && pulses < 200; c++) begin
            tick();
            if (bus.step_done) begin
                pulses++;
                model_step();
                chk($sformatf("run_gap%0d", pulses), c - last, 5);
                chk_xyz($sformatf("run%0d", pulses), mx, my, mz);
                chk($sformatf("run_count%0d", pulses), bus.step_count, pulses);
                last = c;
            end
        end
        chk("run_pulses", pulses, 200);

        bus.run = 1'b0;
        tick();
        tick();
        chk("drop_busy", bus.busy, 1);
        wait_done(10, n);
        chk("drop_latency", n, 3);
        model_step();
        chk_xyz("drop", mx, my, mz);
        chk("drop_count", bus.step_count, 201);
        chk("drop_idle", bus.busy, 0);

        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        repeat (4) tick();
        do_load(tbl[1]);
        chk("ldupd_done", bus.step_done, 0);
        chk("ldupd_count", bus.step_count, 0);
        chk_xyz("ldupd", tbl[1].ix, tbl[1].iy, tbl[1].iz);
        wait_done(6, n);
        chk("ldupd_no_done", n, -1);

        bus.run = 1'b1;
        tick();
        tick();
        tick();
        do_load(tbl[0]);
        chk("ldmul2_busy", bus.busy, 0);
        chk("ldmul2_count", bus.step_count, 0);
        chk_xyz("ldmul2", tbl[0].ix, tbl[0].iy, tbl[0].iz);
        tick();
        chk("ldmul2_accept", bus.busy, 1);
        bus.run = 1'b0;
        wait_done(10, n);
        chk("ldmul2_latency", n, 5);
        chk_xyz("ldmul2_step", tbl[0].ex, tbl[0].ey, tbl[0].ez);
        chk("ldmul2_step_count", bus.step_count, 1);

        do_load(tbl[0]);
        bus.run = 1'b1;
        tick();
        tick();
        bus.sigma = to_q720(5.0);
        wait_done(10, n);
        chk("sig_latency", n, 4);
        model_step();
        chk_xyz("sig_old", mx, my, mz);
        bus.run = 1'b0;
        ms = to_q720(5.0);
        wait_done(10, n);
        chk("sig_latency2", n, 5);
        model_step();
        chk_xyz("sig_new", mx, my, mz);
        chk("sig_count", bus.step_count, 2);

        bus.run = 1'b1;
        tick();
        tick();
        bus.run = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk_xyz("arst", 0, 0, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_count", bus.step_count, 0);
        tick();
        reset = 1'b0;
        wait_done(8, n);
        chk("arst_no_done", n, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
